reg_wr_sched: RTL and testbench
===============================

REG_WR_SCHED -- requirements
Module: reg_wr_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter N_REG, default 8: number of 32-bit registers in the bank (power of 2).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, N_REQ: per-requester write request.
REQ-006 SHALL have port req_addr, input, N_REQ*log2(N_REG): packed target register indices; requester i occupies slice i.
REQ-007 SHALL have port req_data, input, N_REQ*32: packed write data; requester i occupies slice i.
REQ-008 SHALL have port req_ready, output, N_REQ: one-hot grant, or all zero.
REQ-009 SHALL have port rd_addr, input, log2(N_REG): read index.
REQ-010 SHALL have port rd_data, output, 32: read data.
REQ-011 SHALL have port contend_cnt, output, 16: contention counter.

Function
REQ-012 SHALL compute req_ready combinationally each cycle: at most one bit set, only among set req_valid bits.
REQ-013 SHALL arbitrate round-robin: search starts at pointer ptr and ascends modulo N_REQ; the first valid requester wins.
REQ-014 SHALL define a transfer as req_valid[i] & req_ready[i] in one cycle.
REQ-015 SHALL, on a transfer, set ptr to (winner+1) mod N_REQ at the clock edge; with no transfer, ptr SHALL hold.
REQ-016 SHALL, on a transfer, latch addr and data into a stage register and set stage_vld at the edge.
REQ-017 SHALL write stage data into bank[stage_addr] at the edge ending any cycle with stage_vld=1; stage_vld SHALL clear unless a new transfer occurs in the same cycle.
REQ-018 SHALL accept one transfer every cycle, with no bubbles under continuous requests.
REQ-019 SHALL let the later transfer win when consecutive transfers target the same address.
REQ-020 SHALL drive rd_data combinationally from bank[rd_addr]; without forwarding, written data is visible 2 cycles after the transfer cycle.
REQ-021 SHALL increment contend_cnt by 1 at the edge of any cycle with two or more req_valid bits set, saturating at 0xFFFF.
REQ-022 SHALL treat a requester dropping req_valid before grant as legal; no state change results.

Reset
REQ-023 SHALL, while rst=1, force req_ready=0, ignore requests and perform no bank writes.
REQ-024 SHALL, at a reset edge, set ptr=0, stage_vld=0, contend_cnt=0 and all bank entries to 0; rd_data therefore reads 0.
REQ-025 SHALL discard a pending stage write when rst is asserted mid-operation.

Configuration
REQ-026 SHALL use macro REG_WR_SCHED_FWD_EN to control read forwarding.
REQ-027 SHALL, with REG_WR_SCHED_FWD_EN defined, return stage_data on rd_data when stage_vld=1 and stage_addr==rd_addr, giving visibility 1 cycle after transfer.
REQ-028 SHALL, without REG_WR_SCHED_FWD_EN, read the bank only (2-cycle visibility) and omit the comparator.

Structure
REQ-029 SHALL place DATA_W=32, CNT_W=16 and the address-width function in shared package reg_sched_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arbiter (req, ptr in; one-hot grant out; combinational).
REQ-031 SHALL keep ptr, the stage register, the counter and the bank in reg_wr_sched.

Verification
REQ-032 SHALL test: reset, then rd_addr 0..7 -> rd_data=0 and contend_cnt=0.
REQ-033 SHALL test: req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3 and contend_cnt=8.
REQ-034 SHALL test: requester 2 writes 0xDEADBEEF to reg 5 at cycle t -> rd_data=0xDEADBEEF at t+2 (t+1 with FWD_EN).
REQ-035 SHALL test: back-to-back writes of 0x1 then 0x2 to reg 3 -> reg 3 ends at 0x2.
REQ-036 SHALL test: transfer, then rst asserted next cycle -> bank entry stays 0 and ptr=0.
REQ-037 SHALL test: counter preloaded near saturation with sustained contention -> contend_cnt stops at 0xFFFF.

Source files
------------

// File: rtl/reg_sched_pkg.sv
// Shared widths and the address-width helper for the register write scheduler.
package reg_sched_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // Index width for n entries; never below 1 so single-entry vectors stay legal.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and ascends
// modulo N_REQ; the first requester found gets the one-hot grant.
module rr_arbiter
  import reg_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PW    = addr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wr_sched.sv
// Register bank with N_REQ round-robin write ports, one staging register and
// a saturating contention counter. Define REG_WR_SCHED_FWD_EN for read forwarding.
module reg_wr_sched
  import reg_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int N_REG = 8,
  localparam int AW    = addr_w(N_REG),
  localparam int PW    = addr_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic [CNT_W-1:0]      contend_cnt
);

  logic [PW-1:0]     ptr_q, ptr_d;
  logic              stage_vld_q;
  logic [AW-1:0]     stage_addr_q;
  logic [DATA_W-1:0] stage_data_q;
  logic [CNT_W-1:0]  contend_q, contend_d;
  logic [DATA_W-1:0] bank_q [N_REG];

  logic [N_REQ-1:0]  req_gated;
  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     win_idx;
  logic              xfer;
  logic              multi_req;

  // Requests are invisible to the arbiter while in reset, so no grant can issue.
  assign req_gated = rst ? '0 : req_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req_gated),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign multi_req = |(req_valid & (req_valid - 1'b1));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    contend_d = contend_q;
    if (multi_req && contend_q != {CNT_W{1'b1}}) contend_d = contend_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      stage_vld_q  <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      contend_q    <= '0;
      // NOTE: the bank must read back 0 after reset, so it is built from
      // resettable flops rather than an inferred RAM macro.
      for (int i = 0; i < N_REG; i++) bank_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      stage_vld_q <= xfer;
      contend_q   <= contend_d;
      if (xfer) begin
        stage_addr_q <= req_addr[win_idx*AW +: AW];
        stage_data_q <= req_data[win_idx*DATA_W +: DATA_W];
      end
      if (stage_vld_q) bank_q[stage_addr_q] <= stage_data_q;
    end
  end

`ifdef REG_WR_SCHED_FWD_EN
  // A staged write to the read address is returned before it reaches the bank.
  assign rd_data = (stage_vld_q && stage_addr_q == rd_addr) ? stage_data_q
                                                            : bank_q[rd_addr];
`else
  assign rd_data = bank_q[rd_addr];
`endif

  assign contend_cnt = contend_q;

endmodule

// File: tb/tb_reg_wr_sched.sv
// Scoreboard bench for reg_wr_sched: a stimulus process pushes expectations from
// a visibility-delay reference model; a negedge monitor pops and compares.
module tb_reg_wr_sched;
  import reg_sched_pkg::*;

  localparam int N_REQ = 4;
  localparam int N_REG = 8;
  localparam int AW    = 3;
`ifdef REG_WR_SCHED_FWD_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*AW-1:0]     req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [AW-1:0]           rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic [CNT_W-1:0]        contend_cnt;

  reg_wr_sched #(.N_REQ(N_REQ), .N_REG(N_REG)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .contend_cnt (contend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0]  grant;
    logic [DATA_W-1:0] rd;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  typedef struct {
    int                addr;
    logic [DATA_W-1:0] data;
    int                vis;   // first cycle in which a read returns this data
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend[$];

  // Reference model: architectural state only, writes become visible LAT cycles later.
  logic [DATA_W-1:0] mbank [N_REG];
  int                m_ptr;
  logic [CNT_W-1:0]  m_cnt;
  int                cyc;

  logic [N_REQ*AW-1:0]     a_pk;
  logic [N_REQ*DATA_W-1:0] d_pk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N_REQ; i++) begin
      a_pk[i*AW +: AW]         = AW'($urandom_range(N_REG - 1));
      d_pk[i*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  task automatic step(input logic r, input logic [N_REQ-1:0] v, input logic [AW-1:0] ra);
    exp_t  e;
    pend_t p;
    int    win;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_addr  = a_pk;
    req_data  = d_pk;
    rd_addr   = ra;
    while (pend.size() > 0 && pend[0].vis <= cyc) begin
      p = pend.pop_front();
      mbank[p.addr] = p.data;
    end
    win = -1;
    if (!r) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (win < 0 && v[(m_ptr + k) % N_REQ]) win = (m_ptr + k) % N_REQ;
      end
    end
    e.grant = '0;
    if (win >= 0) e.grant[win] = 1'b1;
    e.rd  = mbank[ra];
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (r) begin
      m_ptr = 0;
      m_cnt = '0;
      pend.delete();
      for (int i = 0; i < N_REG; i++) mbank[i] = '0;
    end else begin
      if (win >= 0) begin
        m_ptr  = (win + 1) % N_REQ;
        p.addr = int'(a_pk[win*AW +: AW]);
        p.data = d_pk[win*DATA_W +: DATA_W];
        p.vis  = cyc + LAT;
        pend.push_back(p);
      end
      if ($countones(v) >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",       32'(req_ready),   32'(e.grant));
      check("rd_data",     rd_data,          e.rd);
      check("contend_cnt", 32'(contend_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rd_addr = '0;
    a_pk = '0; d_pk = '0;
    m_ptr = 0; m_cnt = '0; cyc = 0;
    for (int i = 0; i < N_REG; i++) mbank[i] = '0;
    @(posedge clk);

    // Reset state: every register reads 0, counter 0.
    step(1'b1, '0, '0);
    for (int i = 0; i < N_REG; i++) begin
      step(1'b0, '0, AW'(i));
      @(negedge clk);
      check("rd_after_reset", rd_data, 32'h0);
    end

    // Full contention for 8 cycles: strict rotation, counter reaches 8.
    step(1'b1, '0, '0);
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      step(1'b0, 4'b1111, '0);
      @(negedge clk);
      check("rr_sequence", 32'(req_ready), 32'(4'b0001 << (i % 4)));
    end
    step(1'b0, '0, '0);
    @(negedge clk);
    check("cnt_after_8", 32'(contend_cnt), 32'd8);

    // Single write latency: requester 2 writes 0xDEADBEEF to register 5.
    step(1'b1, '0, '0);
    rand_payload();
    a_pk[2*AW +: AW]         = 3'd5;
    d_pk[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    step(1'b0, 4'b0100, 3'd5);
    @(negedge clk);
    check("rd_lat_t0", rd_data, 32'h0);
    for (int j = 1; j <= 3; j++) begin
      step(1'b0, '0, 3'd5);
      @(negedge clk);
      check("rd_lat", rd_data, (j >= LAT) ? 32'hDEADBEEF : 32'h0);
    end

    // Back-to-back writes to the same register: the later one wins.
    step(1'b1, '0, '0);
    rand_payload();
    a_pk[0 +: AW] = 3'd3; d_pk[0 +: DATA_W] = 32'h1;
    step(1'b0, 4'b0001, 3'd3);
    a_pk[AW +: AW] = 3'd3; d_pk[DATA_W +: DATA_W] = 32'h2;
    step(1'b0, 4'b0010, 3'd3);
    repeat (3) step(1'b0, '0, 3'd3);
    @(negedge clk);
    check("same_addr_last_wins", rd_data, 32'h2);

    // Reset right after a transfer discards the staged write and the pointer.
    step(1'b1, '0, '0);
    rand_payload();
    a_pk[AW +: AW] = 3'd6; d_pk[DATA_W +: DATA_W] = 32'hAAAA5555;
    step(1'b0, 4'b0010, 3'd6);
    step(1'b1, '0, 3'd6);
    step(1'b0, '0, 3'd6);
    step(1'b0, '0, 3'd6);
    @(negedge clk);
    check("rst_discards_write", rd_data, 32'h0);
    step(1'b0, 4'b1111, 3'd6);
    @(negedge clk);
    check("rst_clears_ptr", 32'(req_ready), 32'(4'b0001));

    // Randomized traffic with occasional resets and dropped requests.
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      step(($urandom_range(49) == 0) ? 1'b1 : 1'b0,
           N_REQ'($urandom_range((1 << N_REQ) - 1)),
           AW'($urandom_range(N_REG - 1)));
    end

    // Sustained contention drives the counter into saturation.
    step(1'b1, '0, '0);
    for (int i = 0; i < 65540; i++) begin
      rand_payload();
      step(1'b0, 4'b1111, AW'($urandom_range(N_REG - 1)));
    end
    step(1'b0, '0, '0);
    @(negedge clk);
    check("cnt_saturated", 32'(contend_cnt), 32'h0000FFFF);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
